// File: rtl/pad_bus_pkg.sv
// pad_bus_pkg
//   Shared types and helpers for the pad memory-bus sequencer.
//   state_t   : sequencer states (IDLE, TURN, WRITE, READ)
//   dir_t     : bus direction of the last completed operation
//   cnt_width : width of the phase counter for a given timing set
package pad_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        WRITE,
        READ
    } state_t;

    typedef enum logic {
        DIR_RD,
        DIR_WR
    } dir_t;

    // $clog2(max(wr_cyc, rd_lat, turnaround) + 1), never below 1 bit
    function automatic int cnt_width(input int wr_cyc, input int rd_lat, input int turnaround);
        int m;
        m = wr_cyc;
        if (rd_lat > m) m = rd_lat;
        if (turnaround > m) m = turnaround;
        if (m < 1) return 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pad_bus_cnt.sv
// pad_bus_cnt
//   Load/decrement phase counter shared by the TURN, WRITE and READ states.
//   Loaded with N-1 on state entry; the owning state exits when zero is set.
//   Ports:
//     clk      in   clock
//     rst      in   asynchronous active-low reset
//     load     in   load load_val this cycle (has priority over decrement)
//     load_val in   W  value to load
//     cnt      out  W  current count
//     zero     out  count is zero
module pad_bus_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pad_mem_bus_ctrl.sv
// pad_mem_bus_ctrl
//   Sequences single-word core read/write requests onto the memory pads with
//   configurable turnaround, write pulse width and read sampling latency.
//   All pad outputs are registered.
//   Ports:
//     clk, rst             clock, asynchronous active-low reset
//     req_valid/req_ready  request handshake (ready only in IDLE)
//     req_we/addr/wdata    request direction, address, write data
//     rsp_valid/rsp_rdata  one-cycle read-data pulse, data held until next read
//     busy                 sequencer not in IDLE
//     pad_addr/we/oe/dout  registered drives to the address/control/data pads
//     pad_din              data returned from the bidirectional data pads
module pad_mem_bus_ctrl
    import pad_bus_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int WR_CYC     = 1,
    parameter int RD_LAT     = 2,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] pad_addr,
    output logic              pad_we,
    output logic              pad_oe,
    output logic [DATA_W-1:0] pad_dout,
    input  logic [DATA_W-1:0] pad_din
);

    localparam int CW = cnt_width(WR_CYC, RD_LAT, TURNAROUND);

    localparam logic [CW-1:0] WR_LOAD   = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] RD_LOAD   = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_t            state;
    logic              op_we;
    logic [DATA_W-1:0] op_wdata;
    dir_t              last_dir;
    logic              last_dir_valid;

    logic              accept;
    logic              need_turn;
    logic              cnt_load;
    logic [CW-1:0]     cnt_load_val;
    logic [CW-1:0]     cnt;
    logic              cnt_zero;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // Turnaround only when a previous direction is known and it differs
    assign need_turn = last_dir_valid && (req_we != (last_dir == DIR_WR)) && (TURNAROUND > 0);

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = need_turn ? TURN_LOAD : (req_we ? WR_LOAD : RD_LOAD);
                end
            end
            TURN: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = op_we ? WR_LOAD : RD_LOAD;
                end
            end
            default: ;
        endcase
    end

    pad_bus_cnt #(
        .W(CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            op_we          <= 1'b0;
            op_wdata       <= '0;
            last_dir       <= DIR_RD;
            last_dir_valid <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            pad_addr       <= '0;
            pad_we         <= 1'b0;
            pad_oe         <= 1'b0;
            pad_dout       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_we    <= req_we;
                        op_wdata <= req_wdata;
                        pad_addr <= req_addr;
                        if (need_turn) begin
                            state <= TURN;
                        end else if (req_we) begin
                            state    <= WRITE;
                            pad_we   <= 1'b1;
                            pad_oe   <= 1'b1;
                            pad_dout <= req_wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                TURN: begin
                    if (cnt_zero) begin
                        if (op_we) begin
                            state    <= WRITE;
                            pad_we   <= 1'b1;
                            pad_oe   <= 1'b1;
                            pad_dout <= op_wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_zero) begin
                        state          <= IDLE;
                        pad_we         <= 1'b0;
                        pad_oe         <= 1'b0;
                        last_dir       <= DIR_WR;
                        last_dir_valid <= 1'b1;
                    end
                end
                READ: begin
                    if (cnt_zero) begin
                        state          <= IDLE;
                        rsp_rdata      <= pad_din;
                        rsp_valid      <= 1'b1;
                        last_dir       <= DIR_RD;
                        last_dir_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
